store_buffer: RTL and testbench
===============================

# store_buffer

Post-commit store buffer between ROB store commit and the store port of the data-memory arbiter. Holds up to DEPTH committed stores in program order and drains them one at a time through a valid/ready handshake. Gives the load queue a combinational hazard check so a load never reads memory while an older buffered store overlaps its bytes. Contents are architecturally committed, so no flush input exists and nothing is ever squashed.

## Interface
- DEPTH, 4, entry count; power of two, >= 2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset (state cleared while rst == 0)
- enq_valid  in  1  committed store presented
- enq_ready  out  1  buffer can accept; = (count != DEPTH)
- enq_addr  in  32  byte address (word-aligned access, low 2 bits ignored)
- enq_wmask  in  4  byte write mask, nonzero
- enq_wdata  in  32  write data, byte lanes aligned to wmask
- dmem_valid  out  1  head entry present; = (count != 0)
- dmem_ready  in  1  arbiter accepts store this cycle
- dmem_addr  out  32  head address, low 2 bits forced to 0
- dmem_wmask  out  4  head mask
- dmem_wdata  out  32  head data
- ld_chk_addr  in  32  address of load requesting issue
- ld_chk_rmask  in  4  byte mask of that load
- ld_conflict  out  1  some buffered store overlaps the load
- empty  out  1  count == 0
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular FIFO: head/tail pointers of $clog2(DEPTH)+1 bits (extra wrap bit); full when indices equal and wrap bits differ, empty when fully equal. count = tail - head (modular, fits count width).
- Per entry: valid, addr[31:2], wmask, wdata.
- Enqueue on enq_valid && enq_ready: write entry at tail, set valid, tail += 1.
- Dequeue on dmem_valid && dmem_ready: clear head valid, head += 1. Handshake completes the store from the buffer's view; arbiter owns response tracking.
- Simultaneous enqueue and dequeue: both happen; count unchanged. Permitted at any non-full, non-empty occupancy; when full, enq_ready is 0 regardless of dmem_ready (no same-cycle pass-through); when empty, no dequeue (dmem_valid is 0).
- Wrap-around: pointer index wraps DEPTH-1 -> 0 and toggles wrap bit; ordering preserved.
- dmem_* outputs driven purely from head entry registers; stable while dmem_valid && !dmem_ready. dmem_* other than dmem_valid are don't-care when empty.
- ld_conflict = OR over valid entries of (entry.addr[31:2] == ld_chk_addr[31:2]) && |(entry.wmask & ld_chk_rmask). Purely combinational from registered state and ld_chk_* inputs; entry enqueued this cycle not included; entry dequeued this cycle still included. ld_chk_rmask == 0 -> ld_conflict = 0.
- enq_valid while !enq_ready: ignored, no state change; upstream holds.

## Timing
- Reset (rst == 0, asynchronous): head = tail = 0, all valid = 0; hence enq_ready = 1, dmem_valid = 0, empty = 1, count = 0, ld_conflict = 0. Reset mid-operation discards all entries immediately, including one in a handshake that cycle.
- Enqueue-to-dmem_valid latency: 1 cycle (entry enqueued at edge N visible at head after edge N if buffer was empty; no combinational bypass).
- Enqueue-to-ld_conflict visibility: 1 cycle.
- Throughput: one enqueue and one dequeue per cycle.
- enq_ready and dmem_valid depend only on registered state, never on same-cycle inputs.

## Test plan
- Reset then idle -> enq_ready=1, dmem_valid=0, empty=1, count=0, ld_conflict=0 for any ld_chk inputs.
- Enqueue 4 stores (addr 0x100,0x104,0x108,0x10C, wmask 0xF, data 0xA0..0xA3) with dmem_ready=0 -> count=4, enq_ready=0, 5th enq_valid ignored; then dmem_ready=1 -> four handshakes in order 0x100..0x10C with matching data, empty=1 after.
- Continuous enq/deq for 10 stores with dmem_ready=1 -> count stays 1 after fill, pointers wrap twice, output order equals input order; enqueue while full and dmem_ready=1 still blocked that cycle.
- Buffered store addr 0x203 wmask 0x3 -> dmem_addr=0x200; load check 0x200 rmask 0xC -> ld_conflict=0; rmask 0x2 -> 1; addr 0x204 rmask 0xF -> 0; after its handshake edge -> 0.
- Enqueue at cycle N with matching load check -> ld_conflict=0 at N, 1 at N+1; dmem_valid=1 at N+1.
- Fill 3 entries, assert rst=0 asynchronously mid-cycle -> outputs return to reset values before next edge; after release, first enqueued store is first drained.

Source files
------------

// File: rtl/store_buffer_if.sv
// Store-buffer port bundle: commit-side enqueue, arbiter-side drain, and
// the load-queue hazard probe.
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          enq_valid;
  logic          enq_ready;
  logic [31:0]   enq_addr;
  logic [3:0]    enq_wmask;
  logic [31:0]   enq_wdata;

  logic          dmem_valid;
  logic          dmem_ready;
  logic [31:0]   dmem_addr;
  logic [3:0]    dmem_wmask;
  logic [31:0]   dmem_wdata;

  logic [31:0]   ld_chk_addr;
  logic [3:0]    ld_chk_rmask;
  logic          ld_conflict;

  logic          empty;
  logic [CW-1:0] count;

  // Buffer side
  modport slave (
    input  enq_valid, enq_addr, enq_wmask, enq_wdata,
    input  dmem_ready, ld_chk_addr, ld_chk_rmask,
    output enq_ready, dmem_valid, dmem_addr, dmem_wmask, dmem_wdata,
    output ld_conflict, empty, count
  );

  // Commit / arbiter / load-queue side
  modport master (
    output enq_valid, enq_addr, enq_wmask, enq_wdata,
    output dmem_ready, ld_chk_addr, ld_chk_rmask,
    input  enq_ready, dmem_valid, dmem_addr, dmem_wmask, dmem_wdata,
    input  ld_conflict, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Post-commit store buffer: in-order FIFO of committed stores draining to the
// data-memory arbiter, with a combinational load-overlap hazard check.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave sb
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } entry_t;

  entry_t          ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;

  logic [IW-1:0]   hidx;
  logic [IW-1:0]   tidx;
  logic            full_c;
  logic            empty_c;
  logic            enq_fire;
  logic            deq_fire;
  logic            conflict_c;

  assign hidx    = head_q[IW-1:0];
  assign tidx    = tail_q[IW-1:0];
  assign full_c  = (hidx == tidx) && (head_q[IW] != tail_q[IW]);
  assign empty_c = (head_q == tail_q);

  // Full blocks enqueue even when the head drains this cycle: no pass-through.
  assign enq_fire = sb.enq_valid && !full_c;
  assign deq_fire = sb.dmem_ready && !empty_c;

  // Pointers and per-entry valid bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
    end else begin
      if (enq_fire) begin
        vld_q[tidx] <= 1'b1;
        tail_q      <= tail_q + PW'(1);
      end
      if (deq_fire) begin
        vld_q[hidx] <= 1'b0;
        head_q      <= head_q + PW'(1);
      end
    end
  end

  // Entry payload; qualified by vld_q so it needs no reset
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      ent_q[tidx] <= '{addr:  sb.enq_addr[31:2],
                       wmask: sb.enq_wmask,
                       wdata: sb.enq_wdata};
    end
  end

  // Any valid store sharing the load's word and at least one byte lane
  always_comb begin
    conflict_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (ent_q[i].addr == sb.ld_chk_addr[31:2]) &&
          (|(ent_q[i].wmask & sb.ld_chk_rmask))) begin
        conflict_c = 1'b1;
      end
    end
  end

  assign sb.enq_ready   = !full_c;
  assign sb.dmem_valid  = !empty_c;
  assign sb.dmem_addr   = {ent_q[hidx].addr, 2'b00};
  assign sb.dmem_wmask  = ent_q[hidx].wmask;
  assign sb.dmem_wdata  = ent_q[hidx].wdata;
  assign sb.ld_conflict = conflict_c;
  assign sb.empty       = empty_c;
  assign sb.count       = CW'(tail_q - head_q);
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle,
// plus directed literal expectations for ordering, hazards and reset.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;

  store_buffer_if #(.DEPTH(DEPTH)) sbi ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } st_t;

  st_t         mq[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          errors;
  int          checks;
  bit          check_en;
  bit          m_enq;
  bit          m_deq;
  bit          m_conf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the buffer is just an ordered list of committed stores
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else begin
      m_enq = sbi.enq_valid && (mq.size() != DEPTH);
      m_deq = sbi.dmem_ready && (mq.size() != 0);
      if (m_deq) void'(mq.pop_front());
      if (m_enq) mq.push_back('{sbi.enq_addr, sbi.enq_wmask, sbi.enq_wdata});
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      m_conf = 1'b0;
      foreach (mq[i])
        if (mq[i].addr[31:2] == sbi.ld_chk_addr[31:2] && (mq[i].wmask & sbi.ld_chk_rmask) != 4'h0)
          m_conf = 1'b1;
      chk("m_enq_ready", 32'(sbi.enq_ready), 32'(mq.size() != DEPTH));
      chk("m_dmem_valid", 32'(sbi.dmem_valid), 32'(mq.size() != 0));
      chk("m_empty", 32'(sbi.empty), 32'(mq.size() == 0));
      chk("m_count", 32'(sbi.count), 32'(mq.size()));
      chk("m_ld_conflict", 32'(sbi.ld_conflict), 32'(m_conf));
      if (mq.size() != 0) begin
        chk("m_dmem_addr", sbi.dmem_addr, {mq[0].addr[31:2], 2'b00});
        chk("m_dmem_wmask", 32'(sbi.dmem_wmask), 32'(mq[0].wmask));
        chk("m_dmem_wdata", sbi.dmem_wdata, mq[0].wdata);
      end
      if (rst && sbi.dmem_valid && sbi.dmem_ready) begin
        log_addr.push_back(sbi.dmem_addr);
        log_data.push_back(sbi.dmem_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic v, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    sbi.enq_valid = v;
    sbi.enq_addr  = a;
    sbi.enq_wmask = m;
    sbi.enq_wdata = d;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    check_en = 1'b0;
    rst      = 1'b0;
    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    sbi.dmem_ready   = 1'b0;
    sbi.ld_chk_addr  = 32'h0000_0100;
    sbi.ld_chk_rmask = 4'hF;

    // Reset state
    #12;
    chk("rst_enq_ready", 32'(sbi.enq_ready), 32'd1);
    chk("rst_dmem_valid", 32'(sbi.dmem_valid), 32'd0);
    chk("rst_empty", 32'(sbi.empty), 32'd1);
    chk("rst_count", 32'(sbi.count), 32'd0);
    chk("rst_ld_conflict", 32'(sbi.ld_conflict), 32'd0);
    tick();
    rst      = 1'b1;
    check_en = 1'b1;
    tick();

    // Fill to full with arbiter stalled, then drain in order
    clear_log();
    for (int i = 0; i < 4; i++) begin
      drive_enq(1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hA0 + 32'(i));
      tick();
    end
    drive_enq(1'b1, 32'h110, 4'hF, 32'hEE);
    #2;
    chk("full_count", 32'(sbi.count), 32'd4);
    chk("full_enq_ready", 32'(sbi.enq_ready), 32'd0);
    tick();
    chk("full_hold_count", 32'(sbi.count), 32'd4);
    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    sbi.dmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_empty", 32'(sbi.empty), 32'd1);
    chk("drain_n", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("drain_addr", log_addr[i], 32'h100 + 32'(4 * i));
      chk("drain_data", log_data[i], 32'hA0 + 32'(i));
    end

    // Streaming: 10 stores with the arbiter always ready
    clear_log();
    for (int i = 0; i < 10; i++) begin
      drive_enq(1'b1, 32'h300 + 32'(4 * i), 4'hF, 32'hB0 + 32'(i));
      tick();
      chk("stream_count", 32'(sbi.count), 32'd1);
    end
    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    chk("stream_n", 32'(log_addr.size()), 32'd10);
    for (int i = 0; i < 10 && i < log_addr.size(); i++)
      chk("stream_data", log_data[i], 32'hB0 + 32'(i));

    // Full with arbiter ready: enqueue still blocked this cycle
    sbi.dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_enq(1'b1, 32'h600 + 32'(4 * i), 4'hF, 32'hC0 + 32'(i));
      tick();
    end
    drive_enq(1'b1, 32'h610, 4'hF, 32'hC4);
    sbi.dmem_ready = 1'b1;
    #2;
    chk("full_rdy_enq_ready", 32'(sbi.enq_ready), 32'd0);
    tick();
    chk("full_rdy_count", 32'(sbi.count), 32'd3);
    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    chk("full_rdy_empty", 32'(sbi.empty), 32'd1);

    // Byte-lane hazard check on a misaligned address
    sbi.dmem_ready = 1'b0;
    drive_enq(1'b1, 32'h203, 4'h3, 32'h0000_1234);
    tick();
    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    chk("haz_dmem_addr", sbi.dmem_addr, 32'h200);
    sbi.ld_chk_addr = 32'h200; sbi.ld_chk_rmask = 4'hC; #1;
    chk("haz_rmask_c", 32'(sbi.ld_conflict), 32'd0);
    sbi.ld_chk_rmask = 4'h2; #1;
    chk("haz_rmask_2", 32'(sbi.ld_conflict), 32'd1);
    sbi.ld_chk_rmask = 4'h0; #1;
    chk("haz_rmask_0", 32'(sbi.ld_conflict), 32'd0);
    sbi.ld_chk_addr = 32'h204; sbi.ld_chk_rmask = 4'hF; #1;
    chk("haz_other_word", 32'(sbi.ld_conflict), 32'd0);
    sbi.ld_chk_addr = 32'h200; sbi.ld_chk_rmask = 4'h2;
    sbi.dmem_ready = 1'b1; #1;
    chk("haz_deq_cycle", 32'(sbi.ld_conflict), 32'd1);
    tick();
    chk("haz_after_deq", 32'(sbi.ld_conflict), 32'd0);

    // Newly enqueued store becomes visible one edge later
    sbi.dmem_ready = 1'b0;
    sbi.ld_chk_addr = 32'h400; sbi.ld_chk_rmask = 4'h1;
    drive_enq(1'b1, 32'h400, 4'hF, 32'hD0);
    #1;
    chk("vis_conf_n", 32'(sbi.ld_conflict), 32'd0);
    chk("vis_valid_n", 32'(sbi.dmem_valid), 32'd0);
    tick();
    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    chk("vis_conf_n1", 32'(sbi.ld_conflict), 32'd1);
    chk("vis_valid_n1", 32'(sbi.dmem_valid), 32'd1);
    sbi.dmem_ready = 1'b1;
    tick();
    sbi.dmem_ready = 1'b0;

    // Asynchronous reset mid-cycle with three entries buffered
    for (int i = 0; i < 3; i++) begin
      drive_enq(1'b1, 32'h700 + 32'(4 * i), 4'hF, 32'hE0 + 32'(i));
      tick();
    end
    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    sbi.ld_chk_addr = 32'h700; sbi.ld_chk_rmask = 4'hF;
    chk("pre_arst_count", 32'(sbi.count), 32'd3);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(sbi.count), 32'd0);
    chk("arst_empty", 32'(sbi.empty), 32'd1);
    chk("arst_enq_ready", 32'(sbi.enq_ready), 32'd1);
    chk("arst_dmem_valid", 32'(sbi.dmem_valid), 32'd0);
    chk("arst_ld_conflict", 32'(sbi.ld_conflict), 32'd0);
    tick();
    rst = 1'b1;
    clear_log();
    drive_enq(1'b1, 32'h500, 4'hF, 32'hF0);
    tick();
    drive_enq(1'b1, 32'h504, 4'hF, 32'hF1);
    tick();
    drive_enq(1'b0, 32'h0, 4'h0, 32'h0);
    sbi.dmem_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_n", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() > 0) chk("post_rst_first", log_addr[0], 32'h500);
    chk("post_rst_empty", 32'(sbi.empty), 32'd1);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
